// File: rtl/serial_alu_pkg.sv
// Shared definitions for the serial ALU: op encodings, FSM states and
// sizing helpers for the slice counter.
package serial_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of slice steps needed for one full-width operation.
    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice counter width; a single-step ALU still gets a 1-bit counter.
    function automatic int calc_cnt_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    // Ops that go through the adder and produce carry/overflow.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Ops that subtract: B is inverted and the carry chain starts at 1.
    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU cell. Ripple-carry adder plus bitwise logic.
// msb_cin exposes the carry entering the top bit so the caller can derive
// signed overflow when this slice is the most significant one.
module alu_slice
    import serial_alu_pkg::*;
#(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic             binvert,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] result,
    output logic             cout,
    output logic             msb_cin
);

    logic [SLICE-1:0] w_b;
    logic [SLICE-1:0] w_sum;
    logic [SLICE:0]   w_c;

    assign w_b    = binvert ? ~b : b;
    assign w_c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        assign w_sum[i]  = a[i] ^ w_b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & w_b[i]) | (a[i] & w_c[i]) | (w_b[i] & w_c[i]);
    end

    assign cout    = w_c[SLICE];
    assign msb_cin = w_c[SLICE-1];

    // Select the cell output; reserved codes yield zero.
    always_comb begin
        result = '0;
        case (op)
            OP_AND:                 result = a & b;
            OP_OR:                  result = a | b;
            OP_XOR:                 result = a ^ b;
            OP_ADD, OP_SUB, OP_SLT: result = w_sum;
            default:                result = '0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Serial ALU: one alu_slice time-multiplexed over WIDTH/SLICE clocks, LSB
// first, with the inter-slice carry held in a register. Start/Done handshake.
// Optional macro SERIAL_ALU_LOGIC_FASTPATH_EN: logic and reserved ops finish
// on the first RUN edge using a full-width logic evaluation.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_negative
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int CW     = calc_cnt_w(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a, r_b;     // operands, shifted right one slice per step
    logic [WIDTH-1:0] r_acc;        // partial result, filled from the top down
    logic [2:0]       r_op;

    logic [WIDTH-1:0] r_result;
    logic             r_done, r_zero, r_cflag, r_ovf, r_neg;

    logic [SLICE-1:0] w_sl_res;
    logic             w_sl_cout, w_sl_msbcin;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_full;
    logic             w_fast;
    logic             w_last;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_z, w_fin_c, w_fin_v, w_fin_n;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a       (r_a[SLICE-1:0]),
        .b       (r_b[SLICE-1:0]),
        .cin     (r_carry),
        .binvert (is_sub(r_op)),
        .op      (r_op),
        .result  (w_sl_res),
        .cout    (w_sl_cout),
        .msb_cin (w_sl_msbcin)
    );

    // New slice enters at the top; after NSLICE steps slice 0 sits at the LSB.
    assign w_acc_nxt = (r_acc >> SLICE) | (WIDTH'(w_sl_res) << (WIDTH - SLICE));

`ifdef SERIAL_ALU_LOGIC_FASTPATH_EN
    assign w_fast = (r_state == RUN) && !is_arith(r_op);

    // Full-width logic result, valid on the first RUN step while r_a/r_b are unshifted.
    always_comb begin
        w_full = w_acc_nxt;
        if (w_fast) begin
            case (r_op)
                OP_AND:  w_full = r_a & r_b;
                OP_OR:   w_full = r_a | r_b;
                OP_XOR:  w_full = r_a ^ r_b;
                default: w_full = '0;
            endcase
        end
    end
`else
    assign w_fast = 1'b0;
    assign w_full = w_acc_nxt;
`endif

    assign w_last = (r_state == RUN) && ((r_cnt == LAST) || w_fast);

    // Final result and flags, only consumed on the Done-producing edge.
    always_comb begin
        w_fin_res = w_full;
        w_fin_c   = 1'b0;
        w_fin_v   = 1'b0;
        w_fin_n   = w_full[WIDTH-1];
        if (is_arith(r_op)) begin
            w_fin_c = w_sl_cout;
            w_fin_v = w_sl_cout ^ w_sl_msbcin;
            if (r_op == OP_SLT) begin
                w_fin_res = WIDTH'(w_fin_n ^ w_fin_v);
            end
        end
        w_fin_z = (w_fin_res == '0);
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: Start accepted only in IDLE; leave RUN after the last slice.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = RUN;
            RUN:     if (w_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture in IDLE, slice stepping in RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_op    <= OP_AND;
        end else if (r_state == IDLE) begin
            if (i_start) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_op    <= i_op;
                r_cnt   <= '0;
                r_carry <= is_sub(i_op);
                r_acc   <= '0;
            end
        end else begin
            r_a     <= r_a >> SLICE;
            r_b     <= r_b >> SLICE;
            r_acc   <= w_acc_nxt;
            r_carry <= w_sl_cout;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Visible result/flags change only on completion; Done is a one-cycle pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_cflag  <= 1'b0;
            r_ovf    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_result <= w_fin_res;
                r_zero   <= w_fin_z;
                r_cflag  <= w_fin_c;
                r_ovf    <= w_fin_v;
                r_neg    <= w_fin_n;
            end
        end
    end

    assign o_busy     = (r_state == RUN);
    assign o_done     = r_done;
    assign o_result   = r_result;
    assign o_zero     = r_zero;
    assign o_carry    = r_cflag;
    assign o_overflow = r_ovf;
    assign o_negative = r_neg;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: SLICE=1 and SLICE=4 instances against
// an arithmetic reference model; directed corner cases plus random ops.
module tb_serial_alu;

`ifdef SERIAL_ALU_LOGIC_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] r;
        logic z, c, v, n;
    } exp_t;

    localparam exp_t RST_VEC = '{r: 16'h0, z: 1'b1, c: 1'b0, v: 1'b0, n: 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4;
    logic [15:0] a, b;
    logic [2:0]  op;
    logic        sel;

    logic        busy1, done1, z1, c1, v1, n1;
    logic        busy4, done4, z4, c4, v4, n4;
    logic [15:0] res1, res4;

    logic        obs_busy, obs_done;
    exp_t        obs;

    int errs   = 0;
    int checks = 0;
    exp_t prev;

    always #5 clk = ~clk;

    serial_alu #(.WIDTH(16), .SLICE(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_a(a), .i_b(b), .i_op(op),
        .o_busy(busy1), .o_done(done1), .o_result(res1), .o_zero(z1),
        .o_carry(c1), .o_overflow(v1), .o_negative(n1)
    );

    serial_alu #(.WIDTH(16), .SLICE(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a), .i_b(b), .i_op(op),
        .o_busy(busy4), .o_done(done4), .o_result(res4), .o_zero(z4),
        .o_carry(c4), .o_overflow(v4), .o_negative(n4)
    );

    always_comb begin
        obs_busy = sel ? busy4 : busy1;
        obs_done = sel ? done4 : done1;
        obs      = sel ? {res4, z4, c4, v4, n4} : {res1, z1, c1, v1, n1};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 17-bit arithmetic and signed comparison.
    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [16:0] s;
        e = '0;
        s = '0;
        case (o)
            3'd0: e.r = x & y;
            3'd1: e.r = x | y;
            3'd4: e.r = x ^ y;
            3'd2: s = {1'b0, x} + {1'b0, y};
            3'd3, 3'd5: s = {1'b0, x} + {1'b0, ~y} + 17'd1;
            default: e.r = '0;
        endcase
        if (o == 3'd2 || o == 3'd3 || o == 3'd5) begin
            e.c = s[16];
            e.n = s[15];
            if (o == 3'd2) e.v = (x[15] == y[15]) && (s[15] != x[15]);
            else           e.v = (x[15] != y[15]) && (s[15] != x[15]);
            e.r = (o == 3'd5) ? {15'b0, ($signed(x) < $signed(y))} : s[15:0];
        end else begin
            e.n = e.r[15];
        end
        e.z = (e.r == 16'h0);
        return e;
    endfunction

    function automatic int exp_lat(input bit s, input logic [2:0] o);
        if (FAST && !(o == 3'd2 || o == 3'd3 || o == 3'd5)) return 1;
        return s ? 4 : 16;
    endfunction

    // One operation; b2b starts it in the current (Done) cycle, glitch pulses
    // Start with fresh operands at that RUN cycle.
    task automatic do_op(input string tag, input bit s, input logic [2:0] o,
                         input logic [15:0] x, input logic [15:0] y,
                         input bit b2b, input int glitch);
        exp_t e;
        int   cyc;
        bit   hold_ok, busy_ok;
        e   = model(o, x, y);
        sel = s;
        if (!b2b) @(negedge clk);
        a = x; b = y; op = o;
        if (s) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0; start4 = 1'b0;
        cyc = 0; hold_ok = 1'b1; busy_ok = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (obs_done === 1'b1 || cyc > 60) break;
            if (obs_busy !== 1'b1) busy_ok = 1'b0;
            if (obs !== prev) hold_ok = 1'b0;
            if (cyc == glitch) begin
                a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
                if (s) start4 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0; start4 = 1'b0;
            end
        end
        start1 = 1'b0; start4 = 1'b0;
        chk($sformatf("%s lat", tag), cyc - 1, exp_lat(s, o));
        chk($sformatf("%s busy", tag), {31'b0, busy_ok}, 32'd1);
        chk($sformatf("%s hold", tag), {31'b0, hold_ok}, 32'd1);
        chk($sformatf("%s busy_off", tag), {31'b0, obs_busy}, 32'd0);
        chk($sformatf("%s result", tag), {16'b0, obs.r}, {16'b0, e.r});
        chk($sformatf("%s zcvn", tag), {28'b0, obs.z, obs.c, obs.v, obs.n},
            {28'b0, e.z, e.c, e.v, e.n});
        prev = e;
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] edges [4];
        edges[0] = 16'h0000; edges[1] = 16'hFFFF; edges[2] = 16'h7FFF; edges[3] = 16'h8000;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    initial begin
        bit saw_done;
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; a = '0; b = '0; op = '0; sel = 1'b0;
        prev = RST_VEC;
        repeat (2) @(negedge clk);
        chk("rst busy1", {31'b0, busy1}, 32'd0);
        chk("rst done1", {31'b0, done1}, 32'd0);
        chk("rst vec1", {12'b0, obs}, {12'b0, RST_VEC});
        sel = 1'b1; #1;
        chk("rst vec4", {12'b0, obs}, {12'b0, RST_VEC});
        rst = 1'b0;

        do_op("add_ovf", 0, 3'd2, 16'h7FFF, 16'h0001, 0, 0);
        @(negedge clk);
        chk("done_pulse", {31'b0, done1}, 32'd0);
        do_op("sub_eq",   0, 3'd3, 16'h0005, 16'h0005, 0, 0);
        do_op("sub_neg",  0, 3'd3, 16'h0000, 16'h0001, 0, 0);
        do_op("slt_m1",   0, 3'd5, 16'hFFFF, 16'h0001, 0, 0);
        do_op("slt_ovf",  0, 3'd5, 16'h8000, 16'h7FFF, 0, 0);
        do_op("slt_gt",   0, 3'd5, 16'h0003, 16'h0002, 0, 0);
        do_op("rsvd",     0, 3'd6, 16'h1234, 16'h5678, 0, 0);
        do_op("glitch",   0, 3'd2, 16'h1111, 16'h2222, 0, 5);
        do_op("b2b_a",    0, 3'd3, 16'h4000, 16'hC000, 0, 0);
        do_op("b2b_b",    0, 3'd2, 16'hABCD, 16'h1234, 1, 0);

        // Reset in the middle of a RUN: immediate abort, no Done afterwards.
        sel = 1'b0;
        @(negedge clk);
        a = 16'h00F0; b = 16'h0F00; op = 3'd2; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'b0, busy1}, 32'd0);
        chk("midrst done", {31'b0, done1}, 32'd0);
        chk("midrst vec", {12'b0, obs}, {12'b0, RST_VEC});
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done1 === 1'b1) saw_done = 1'b1;
        end
        chk("midrst no_done", {31'b0, saw_done}, 32'd0);
        prev = RST_VEC;
        do_op("after_rst", 0, 3'd2, 16'h0102, 16'h0304, 0, 0);

        for (int i = 0; i < 40; i++)
            do_op($sformatf("rnd1_%0d", i), 0, 3'($urandom_range(0, 7)), pick(), pick(), 0, 0);

        // SLICE=4 instance; its held outputs are still at reset values.
        prev = RST_VEC;
        do_op("s4_xor", 1, 3'd4, 16'hF0F0, 16'hFF00, 0, 0);
        do_op("s4_and", 1, 3'd0, 16'hFFFF, 16'h0000, 0, 0);
        do_op("s4_add", 1, 3'd2, 16'h7FFF, 16'h0001, 0, 0);
        do_op("s4_slt", 1, 3'd5, 16'h8000, 16'h7FFF, 0, 0);
        for (int i = 0; i < 30; i++)
            do_op($sformatf("rnd4_%0d", i), 1, 3'($urandom_range(0, 7)), pick(), pick(), 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
